// File: rtl/fp_conv_pkg.sv
// rtl/fp_conv_pkg.sv - shared widths, limits and FSM states for the fp converter
package fp_conv_pkg;

    localparam int D_W = 12;
    localparam int E_W = 3;
    localparam int F_W = 4;

    localparam logic [E_W-1:0] E_MAX   = 3'd7;
    localparam logic [F_W-1:0] F_MAX   = 4'b1111;
    localparam logic [F_W-1:0] F_CARRY = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fp_abs_sat.sv
// rtl/fp_abs_sat.sv - two's-complement to sign/magnitude with saturation of the most negative code
module fp_abs_sat
    import fp_conv_pkg::*;
(
    input  logic [D_W-1:0] d_i,
    output logic           sign_o,
    output logic [D_W-1:0] mag_o
);

    always_comb begin
        sign_o = d_i[D_W-1];
        mag_o  = d_i;
        // -2048 has no positive counterpart in 12 bits, so clamp to +2047
        if (d_i == {1'b1, {(D_W-1){1'b0}}}) begin
            mag_o = {1'b0, {(D_W-1){1'b1}}};
        end else if (d_i[D_W-1]) begin
            mag_o = ~d_i + {{(D_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fp_convert_seq.sv
// rtl/fp_convert_seq.sv - sequential 12-bit integer to S/E3/F4 float converter with handshakes
module fp_convert_seq
    import fp_conv_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [D_W-1:0] D,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           S,
    output logic [E_W-1:0] E,
    output logic [F_W-1:0] F,
    output logic           busy
);

    state_e          state_q;
    logic [D_W-1:0]  m_q;
    logic [E_W-1:0]  e_q;
    logic            sign_q;
    logic            s_q;
    logic [E_W-1:0]  e_out_q;
    logic [F_W-1:0]  f_out_q;

    logic            abs_sign;
    logic [D_W-1:0]  abs_mag;
    logic [F_W-1:0]  sig;
    logic            fifth;
    logic [E_W-1:0]  e_rnd_d;
    logic [F_W-1:0]  f_rnd_d;

    fp_abs_sat u_abs (
        .d_i    (D),
        .sign_o (abs_sign),
        .mag_o  (abs_mag)
    );

    assign sig   = m_q[D_W-2 -: F_W];
    assign fifth = m_q[D_W-2-F_W];

    // Round half up on the bit below the significand; a carry out renormalises
    // to 1000 with the exponent bumped, except at the top where it saturates.
    always_comb begin
        e_rnd_d = e_q;
        f_rnd_d = sig;
        if (fifth) begin
            if (sig != F_MAX) begin
                f_rnd_d = sig + {{(F_W-1){1'b0}}, 1'b1};
            end else if (e_q != E_MAX) begin
                e_rnd_d = e_q + {{(E_W-1){1'b0}}, 1'b1};
                f_rnd_d = F_CARRY;
            end else begin
                e_rnd_d = E_MAX;
                f_rnd_d = F_MAX;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            e_q     <= '0;
            sign_q  <= 1'b0;
            s_q     <= 1'b0;
            e_out_q <= '0;
            f_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q  <= abs_sign;
                        m_q     <= abs_mag;
                        e_q     <= E_MAX;
                        state_q <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    // e==0 stops a small value early: it stays a denormal
                    if (e_q == '0 || m_q[D_W-2]) begin
                        state_q <= ST_ROUND;
                    end else begin
                        m_q <= m_q << 1;
                        e_q <= e_q - {{(E_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_ROUND: begin
                    s_q     <= sign_q;
                    e_out_q <= e_rnd_d;
                    f_out_q <= f_rnd_d;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign S         = s_q;
    assign E         = e_out_q;
    assign F         = f_out_q;

endmodule

// File: tb/tb_fp_convert_seq.sv
// tb/tb_fp_convert_seq.sv - scoreboard bench for fp_convert_seq
module tb_fp_convert_seq;

    typedef struct packed {
        logic       s;
        logic [2:0] e;
        logic [3:0] f;
        logic [3:0] lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    int   acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_convert_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .busy      (busy)
    );

    // Value-level reference: pick the exponent from the MSB position, round half up.
    function automatic exp_t model(input logic [11:0] d);
        exp_t r;
        int sv, mag, msb, p, fv, rb, k;
        sv  = int'($signed(d));
        mag = (sv < 0) ? -sv : sv;
        if (mag > 2047) mag = 2047;
        msb = -1;
        for (int i = 0; i < 12; i++) if (((mag >> i) & 1) == 1) msb = i;
        r.s = d[11];
        if (mag < 16) begin
            r.e   = 3'd0;
            r.f   = mag[3:0];
            r.lat = 4'd9;
        end else begin
            p  = msb - 3;
            fv = mag >> p;
            rb = (mag >> (p - 1)) & 1;
            fv = fv + rb;
            if (fv == 16) begin fv = 8; p = p + 1; end
            if (p > 7) begin p = 7; fv = 15; end
            k = (10 - msb < 7) ? 10 - msb : 7;
            r.e   = p[2:0];
            r.f   = fv[3:0];
            r.lat = 4'(k + 2);
        end
        return r;
    endfunction

    task automatic collect_result(input string name);
        exp_t ex;
        int   a;
        int   waited = 0;
        while (!out_valid && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        n_tests++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid=%b required 1 within 30 cycles", name, out_valid);
            sb.delete();
            acc_q.delete();
            return;
        end
        ex = sb.pop_front();
        a  = acc_q.pop_front();
        if ({S, E, F} !== {ex.s, ex.e, ex.f}) begin
            n_fail++;
            $display("FAIL %s result: S=%b E=%0d F=%b required S=%b E=%0d F=%b",
                     name, S, E, F, ex.s, ex.e, ex.f);
        end
        n_tests++;
        if (cyc - a !== int'(ex.lat)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", name, cyc - a, ex.lat);
        end
    endtask

    task automatic run_conv(input logic [11:0] d, input string name);
        int w = 0;
        while (!in_ready && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        sb.push_back(model(d));
        D        = d;
        in_valid = 1'b1;
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect_result(name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        D         = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, busy, out_valid, S, E, F} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b busy=%b ov=%b S=%b E=%0d F=%b required 1 0 0 0 0 0000",
                     in_ready, busy, out_valid, S, E, F);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: rdy/busy/ov=%b required 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_vectors();
        run_conv(12'h000, "zero");
        run_conv(12'd422, "d422");
        run_conv(12'd125, "d125_carry");
        run_conv(12'h800, "neg_sat");
        run_conv(12'h7FF, "pos_sat");
        run_conv(12'd16,  "d16");
        run_conv(12'hC00, "neg1024");
    endtask

    task automatic test_hold();
        exp_t ex_first;
        int   w = 0;
        ex_first = model(12'hFFF);
        sb.push_back(ex_first);
        D        = 12'hFFF;
        in_valid = 1'b1;
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        D = 12'h123;
        collect_result("minus_one");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({out_valid, in_ready, busy, S, E, F} !==
                {1'b1, 1'b0, 1'b1, ex_first.s, ex_first.e, ex_first.f}) begin
                n_fail++;
                $display("FAIL hold cycle %0d: ov=%b rdy=%b busy=%b S=%b E=%0d F=%b required 1 0 1 %b %0d %b",
                         i, out_valid, in_ready, busy, S, E, F, ex_first.s, ex_first.e, ex_first.f);
            end
        end
        sb.push_back(model(12'h123));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_valid_accept: busy=%b required 1", busy);
        end
        collect_result("held_0x123");
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        while (!in_ready && w < 5) begin @(posedge clk); #1; w++; end
    endtask

    task automatic test_reset_mid();
        D        = 12'd37;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, busy, out_valid, S, E, F} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%b busy=%b ov=%b S=%b E=%0d F=%b required 1 0 0 0 0 0000",
                     in_ready, busy, out_valid, S, E, F);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_conv(12'd37, "d37_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [11:0] vals[16];
        int idx = 0;
        int prev_acc = -1;
        int prev_lat = 0;
        int c = 0;
        vals[0] = 12'h000; vals[1] = 12'h001; vals[2] = 12'h400; vals[3] = 12'hC00;
        vals[4] = 12'd1023; vals[5] = 12'd15; vals[6] = 12'hFF0; vals[7] = 12'd127;
        for (int i = 8; i < 16; i++) vals[i] = 12'($urandom);
        out_ready = 1'b1;
        while ((idx < 16 || sb.size() > 0) && c < 400) begin
            if (out_valid && sb.size() > 0) begin
                prev_lat = cyc - acc_q[0];
                collect_result("b2b");
            end
            if (in_ready && idx < 16) begin
                if (prev_acc >= 0) begin
                    n_tests++;
                    if (cyc + 1 - prev_acc !== prev_lat + 2) begin
                        n_fail++;
                        $display("FAIL b2b spacing: got %0d required %0d", cyc + 1 - prev_acc, prev_lat + 2);
                    end
                end
                D        = vals[idx];
                in_valid = 1'b1;
                sb.push_back(model(vals[idx]));
                acc_q.push_back(cyc + 1);
                prev_acc = cyc + 1;
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (sb.size() != 0 || idx != 16) begin
            n_fail++;
            $display("FAIL b2b drain: %0d results pending, %0d sent, required 0 and 16", sb.size(), idx);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_convert_seq.md
# fp_convert_seq

Sequential 12-bit two's-complement to 8-bit floating-point converter with valid/ready handshakes on both sides. The output format is sign S, 3-bit exponent E and 4-bit significand F, with value = F × 2^E. An FSM steps the datapath through sign/magnitude capture, one-bit-per-cycle normalisation, rounding, and result hold. It sits between the switch/input sampling logic and the display/result consumer of the FP conversion lab.

## Interface
- Parameters: none. Widths are fixed by constants in `fp_conv_pkg`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: D is valid.
- `in_ready` output 1: block accepts D. High only in IDLE.
- `D` input 12: two's-complement operand, sampled on the accept edge.
- `out_valid` output 1: S/E/F hold a finished result.
- `out_ready` input 1: consumer takes the result.
- `S` output 1: sign.
- `E` output 3: exponent.
- `F` output 4: significand.
- `busy` output 1: high when state is not IDLE.

## Operation
- States: IDLE, NORM, ROUND, DONE.
- **IDLE**
  - in_ready=1.
  - Accept = in_valid & in_ready at an edge.
  - On accept: sign ← D[11]; m ← |D| as 12 bits; e ← 7; go to NORM.
  - Saturation: D=12'h800 gives m=12'h7FF. m[11] is therefore always 0.
- **NORM**, evaluated each cycle:
  - If e==0 or m[10]==1, go to ROUND.
  - Otherwise m ← m<<1 (zero fill) and e ← e−1.
  - k = number of shifts, 0..7. k = min(lz−1, 7), where lz counts leading zeros of m from bit 11.
- **ROUND**: one cycle. Let sig=m[10:7] and fifth=m[6].
  - fifth=0: E←e, F←sig.
  - fifth=1 and sig≠4'b1111: E←e, F←sig+1.
  - fifth=1, sig=4'b1111, e≠7: E←e+1, F←4'b1000.
  - fifth=1, sig=4'b1111, e=7: E←7, F←4'b1111 (saturate, no wrap).
  - S←sign. Go to DONE.
- **DONE**
  - out_valid=1. S/E/F are held stable.
  - On out_valid & out_ready, go to IDLE.
- e=0 path: after 7 shifts m[6] is a shifted-in zero, so denormal results never round.
- Zero input gives S=0, E=0, F=0. Negative zero cannot occur.

## Timing
- Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, S=0, E=0, F=0. Internal m, e and sign are cleared.
- Reset is asynchronous. Asserting rst_n mid-NORM, ROUND or DONE discards the conversion, and outputs take reset values immediately.
- Latency: accept edge to out_valid rising is k+2 cycles. The minimum is 2 (|D|≥1024); the maximum is 9 (|D|<16).
- in_ready, out_valid and busy are decoded from registered state only, with no combinational in→out paths.
- Minimum accept-to-accept spacing is k+4 cycles with out_ready held high.
- No input accept while busy. A held in_valid is accepted on the first IDLE cycle.
- out_ready is ignored outside DONE.
- S/E/F change only on the ROUND→DONE edge and reset.

## Structure
- `fp_conv_pkg` contents:
  - state enum.
  - D_W=12, E_W=3, F_W=4.
  - E_MAX=3'd7, F_MAX=4'b1111, F_CARRY=4'b1000.
- Sub-module `fp_abs_sat`: combinational D[11:0] → {sign, m[11:0]}, including the 12'h800 → 12'h7FF saturation. Instantiated once in IDLE capture.
- Normalisation, rounding and the FSM are in the top module. Target is about 150–250 lines.

## Test plan
- D=12'h000 → S=0, E=0, F=0000; out_valid 9 cycles after accept.
- D=12'd422 → S=0, E=5, F=1101 (fifth bit 0); latency 4.
- D=12'd125 → round carry: S=0, E=4, F=1000 (k=4).
- D=12'h800 and D=12'h7FF → S=1/S=0 respectively, E=7, F=1111 in both cases (saturation, no exponent wrap).
- D=12'hFFF → S=1, E=0, F=0001, latency 9. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0, busy=1.
- Pulse rst_n low during NORM of D=12'd37 → outputs zero at once, in_ready=1. Next D=12'd37 → S=0, E=2, F=1001 (37 → 36 = 9×4).
